// File: rtl/kmap_score_checker.sv
// kmap_score_checker: scores ref/dut output agreement over a fixed-length run.
// Optional streak tracking when KMAP_CHK_STREAK_EN is defined.
module kmap_score_checker #(
  parameter int CNT_W       = 16,
  parameter int NUM_SAMPLES = 210
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sample_valid,
  input  logic             ref_out,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [CNT_W-1:0] max_streak
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(NUM_SAMPLES - 1);

  state_t state_q;
  state_t state_d;
  logic   accept;
  logic   mis;
  logic   last;

  assign accept = (state_q == RUN) && sample_valid && !start;
  assign mis    = ref_out ^ dut_out;
  assign last   = (sample_cnt == LAST);
  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (start) state_d = RUN;
        else if (accept && last) state_d = DONE;
      end
      DONE: if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      sample_cnt    <= '0;
      err_cnt       <= '0;
      first_err_idx <= ALL_ONES;
    end else begin
      state_q <= state_d;
      if (start) begin
        sample_cnt    <= '0;
        err_cnt       <= '0;
        first_err_idx <= ALL_ONES;
      end else if (accept) begin
        sample_cnt <= sample_cnt + ONE;
        if (mis) begin
          if (err_cnt != ALL_ONES) err_cnt <= err_cnt + ONE;
          // err_cnt saturates, so zero marks "no mismatch yet"
          if (err_cnt == '0) first_err_idx <= sample_cnt;
        end
      end
    end
  end

`ifdef KMAP_CHK_STREAK_EN
  logic [CNT_W-1:0] streak_q;
  logic [CNT_W-1:0] streak_inc;

  assign streak_inc = (streak_q == ALL_ONES) ? streak_q : streak_q + ONE;

  always_ff @(posedge clk) begin
    if (reset || start) begin
      streak_q   <= '0;
      max_streak <= '0;
    end else if (accept) begin
      if (mis) begin
        streak_q <= streak_inc;
        if (streak_inc > max_streak) max_streak <= streak_inc;
      end else begin
        streak_q <= '0;
      end
    end
  end
`else
  assign max_streak = '0;
`endif

endmodule

// File: tb/tb_kmap_score_checker.sv
// tb_kmap_score_checker: random + directed stimulus, scoreboard-checked
// against a run-history model, on a default and a 4-bit instance.
module tb_kmap_score_checker;

  localparam int N0 = 210;
  localparam int W0 = 16;
  localparam int N1 = 15;
  localparam int W1 = 4;

  typedef struct {
    int busy;
    int done;
    int sc;
    int ec;
    int fe;
    int ms;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic sample_valid = 1'b0;
  logic ref_out = 1'b0;
  logic dut_out = 1'b0;

  logic          busy0, done0, busy1, done1;
  logic [W0-1:0] sc0, ec0, fe0, ms0;
  logic [W1-1:0] sc1, ec1, fe1, ms1;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];

  // model: per instance, the mismatch history of the current run
  bit hist[2][256];
  int len[2];
  int st[2];

  always #5 clk = ~clk;

  kmap_score_checker #(.CNT_W(W0), .NUM_SAMPLES(N0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .sample_valid(sample_valid),
    .ref_out(ref_out), .dut_out(dut_out), .busy(busy0), .done(done0),
    .sample_cnt(sc0), .err_cnt(ec0), .first_err_idx(fe0), .max_streak(ms0)
  );

  kmap_score_checker #(.CNT_W(W1), .NUM_SAMPLES(N1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .sample_valid(sample_valid),
    .ref_out(ref_out), .dut_out(dut_out), .busy(busy1), .done(done1),
    .sample_cnt(sc1), .err_cnt(ec1), .first_err_idx(fe1), .max_streak(ms1)
  );

  function automatic void chk(string nm, int act, int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, req);
    end
  endfunction

  function automatic void model(int k, int n, int w, bit rs, bit s,
                                bit v, bit r, bit d);
    exp_t e;
    int   sat = (1 << w) - 1;
    int   run = 0;
    bit   seen = 0;
    if (rs) begin
      st[k] = 0;
      len[k] = 0;
    end else if (s) begin
      st[k] = 1;
      len[k] = 0;
    end else if (st[k] == 1 && v) begin
      hist[k][len[k]] = (r != d);
      len[k]++;
      if (len[k] == n) st[k] = 2;
    end
    e.busy = (st[k] == 1) ? 1 : 0;
    e.done = (st[k] == 2) ? 1 : 0;
    e.sc = len[k];
    e.ec = 0;
    e.fe = sat;
    e.ms = 0;
    for (int i = 0; i < len[k]; i++) begin
      if (hist[k][i]) begin
        e.ec++;
        if (!seen) e.fe = i;
        seen = 1;
        run++;
        if (run > e.ms) e.ms = run;
      end else begin
        run = 0;
      end
    end
    if (e.ec > sat) e.ec = sat;
    if (e.ms > sat) e.ms = sat;
`ifndef KMAP_CHK_STREAK_EN
    e.ms = 0;
`endif
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  task automatic step(input bit rs, input bit s, input bit v,
                      input bit r, input bit d);
    @(negedge clk);
    reset = rs;
    start = s;
    sample_valid = v;
    ref_out = r;
    dut_out = d;
    model(0, N0, W0, rs, s, v, r, d);
    model(1, N1, W1, rs, s, v, r, d);
  endtask

  // monitor: outputs settle after each posedge; compare against oldest entry
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("big_busy", int'(busy0), e.busy);
        chk("big_done", int'(done0), e.done);
        chk("big_sample_cnt", int'(sc0), e.sc);
        chk("big_err_cnt", int'(ec0), e.ec);
        chk("big_first_err_idx", int'(fe0), e.fe);
        chk("big_max_streak", int'(ms0), e.ms);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("small_busy", int'(busy1), e.busy);
        chk("small_done", int'(done1), e.done);
        chk("small_sample_cnt", int'(sc1), e.sc);
        chk("small_err_cnt", int'(ec1), e.ec);
        chk("small_first_err_idx", int'(fe1), e.fe);
        chk("small_max_streak", int'(ms1), e.ms);
      end
    end
  end

  initial begin
    bit b;
    st[0] = 0; st[1] = 0; len[0] = 0; len[1] = 0;
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 1);
    step(0, 0, 1, 0, 1);

    // clean run of all matches
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < N0; i++) begin
      b = 1'($urandom);
      step(0, 0, 1, b, b);
    end
    step(0, 0, 0, 0, 0);

    // mismatches at 3,4,5,100
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < N0; i++) begin
      b = (i == 3 || i == 4 || i == 5 || i == 100);
      step(0, 0, 1, 0, b);
    end
    // samples after done are ignored
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0);

    // restart mid-run with a sample in the start cycle
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 50; i++) step(0, 0, 1, 0, (i % 7 == 0 && i < 49));
    step(0, 1, 1, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, (i == 2));

    // reset mid-run, then ignored samples until start
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 1);
    step(1, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 1);

    // all-mismatch run saturates the 4-bit instance
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit rs, s, v, r, d;
      rs = ($urandom % 400 == 0);
      s  = ($urandom % 90 == 0);
      v  = ($urandom % 4 != 0);
      r  = 1'($urandom);
      d  = ($urandom % 3 == 0) ? ~r : r;
      step(rs, s, v, r, d);
    end
    step(0, 0, 0, 0, 0);

    repeat (4) @(posedge clk);
    #3;
    n_chk++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: actual=%0d required=0", q0.size() + q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/kmap_score_checker.md
KMAP_SCORE_CHECKER -- requirements
Module: kmap_score_checker

Interface
REQ-001 Parameter CNT_W, default 16: width of all counters and indices.
REQ-002 Parameter NUM_SAMPLES, default 210: samples per run; legal range 1 to 2^CNT_W-1.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port start  input  1: single-cycle request to begin (or restart) a scoring run.
REQ-006 Port sample_valid  input  1: ref_out/dut_out form one sample this cycle.
REQ-007 Port ref_out  input  1: reference-model output for the sample.
REQ-008 Port dut_out  input  1: device-under-test output for the sample.
REQ-009 Port busy  output  1: high while in RUN.
REQ-010 Port done  output  1: high while in DONE.
REQ-011 Port sample_cnt  output  CNT_W: samples accepted in the current run.
REQ-012 Port err_cnt  output  CNT_W: mismatching samples in the current run.
REQ-013 Port first_err_idx  output  CNT_W: 0-based index of the first mismatch; all-ones if none.
REQ-014 Port max_streak  output  CNT_W: longest run of consecutive mismatching samples.

Function
REQ-015 The block SHALL implement three states (IDLE, RUN, DONE); busy=(RUN), done=(DONE).
- IDLE: start -> RUN; otherwise stay.
- RUN: accepted sample that makes sample_cnt equal NUM_SAMPLES -> DONE; otherwise stay.
- DONE: start -> RUN; otherwise stay.
REQ-016 On the edge where start is taken, the block SHALL clear sample_cnt, err_cnt, the current streak and max_streak, and set first_err_idx to all-ones; a sample_valid in that same cycle SHALL be ignored.
REQ-017 start asserted in RUN SHALL restart the run with the same clearing as REQ-016. start SHALL take priority over sample_valid.
REQ-018 A sample SHALL be accepted only when the state is RUN, sample_valid=1 and start=0; samples in IDLE or DONE SHALL be ignored.
REQ-019 Mismatch is defined as ref_out != dut_out.
REQ-020 All outputs SHALL be registered; the effect of an accepted sample SHALL be visible on outputs exactly one cycle after its sampling edge.
REQ-021 Each accepted sample SHALL increment sample_cnt by 1. Each accepted mismatch SHALL increment err_cnt by 1, saturating at 2^CNT_W-1.
REQ-022 On the first accepted mismatch of a run, first_err_idx SHALL load the pre-increment sample_cnt; later mismatches SHALL leave it unchanged.
REQ-023 The final sample (sample_cnt NUM_SAMPLES-1 -> NUM_SAMPLES) SHALL be scored normally, and done SHALL rise in the same cycle that the final counts appear.
REQ-024 Outputs SHALL hold stable in DONE and IDLE until the next start.

Reset
REQ-025 When reset=1 at a clock edge, the block SHALL enter IDLE and overrides start and sample_valid.
REQ-026 Reset values: busy=0, done=0, sample_cnt=0, err_cnt=0, max_streak=0, first_err_idx=all-ones, internal streak=0.
REQ-027 Reset during RUN SHALL abort the run; the partial results SHALL be discarded.

Configuration
REQ-028 Macro KMAP_CHK_STREAK_EN controls the streak feature.
REQ-029 Defined: an internal streak counter SHALL increment on each accepted mismatch (saturating), clear on each accepted match, and max_streak SHALL update to max(max_streak, new streak) in the same edge.
REQ-030 Undefined: the streak logic SHALL NOT exist, and max_streak SHALL be constant 0.

Verification
REQ-031 reset, start, 210 samples with ref_out=dut_out -> done=1, sample_cnt=210, err_cnt=0, first_err_idx=16'hFFFF, max_streak=0.
REQ-032 Mismatches at sample indices 3, 4, 5 and 100, NUM_SAMPLES=210 -> err_cnt=4, first_err_idx=3; max_streak=3 with KMAP_CHK_STREAK_EN, else 0.
REQ-033 Five samples after done, all mismatching -> all outputs unchanged, done stays 1.
REQ-034 start at sample 50 of a run that already has 7 errors -> next cycle sample_cnt=0, err_cnt=0, first_err_idx=all-ones, busy=1; a sample_valid in the start cycle is not counted.
REQ-035 reset asserted mid-run at sample 20 -> next cycle IDLE, all outputs at reset values; later sample_valid pulses are ignored until start.
REQ-036 CNT_W=4, NUM_SAMPLES=15, every sample a mismatch -> err_cnt=15, max_streak=15 with the macro defined, done=1.
